// File: rtl/placar_pontuacao.sv
// ============================================================================
// placar_pontuacao: basketball scoreboard score register stage.
// Synchronizes and debounces the confirm button, then applies one add or
// subtract per press using the external comparator's underflow flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module placar_pontuacao #(
    parameter int MAX_PONTOS      = 99,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       botao,
    input  logic       chavePN,
    input  logic       chaveTime,
    input  logic [1:0] pontos,
    input  logic       bloqueio,
    output logic [6:0] scoreSel,
    output logic       pnReg,
    output logic [1:0] pontosReg,
    output logic [6:0] scoreA,
    output logic [6:0] scoreB,
    output logic       erro,
    output logic       ocupado
);

    localparam int               CNT_W   = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [7:0]       MAX_8   = 8'(MAX_PONTOS);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        CAPTURA       = 2'd1,
        AVALIA        = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    estado_t          estado_q;
    logic             timeReg_q;
    logic             pn_q;
    logic [1:0]       pontos_q;
    logic [6:0]       scoreA_q;
    logic [6:0]       scoreB_q;
    logic             erro_q;
    logic             ocupado_q;

    logic [7:0]       soma_d;
    logic [6:0]       diff_d;
    logic             excede_d;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], botao};
        end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = press_q;
        if (sync_q[1] == press_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_FIM) begin
            press_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounced level resets high so a button held through reset is ignored.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_q   <= '0;
            press_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign scoreSel = timeReg_q ? scoreB_q : scoreA_q;
    assign soma_d   = {1'b0, scoreSel} + {6'b0, pontos_q};
    assign diff_d   = scoreSel - {5'b0, pontos_q};
    assign excede_d = (soma_d > MAX_8);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            estado_q  <= ESPERA_SOLTAR;
            timeReg_q <= 1'b0;
            pn_q      <= 1'b0;
            pontos_q  <= 2'd0;
            scoreA_q  <= 7'd0;
            scoreB_q  <= 7'd0;
            erro_q    <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            erro_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (press_q) begin
                        timeReg_q <= chaveTime;
                        pn_q      <= chavePN;
                        pontos_q  <= pontos;
                        ocupado_q <= 1'b1;
                        estado_q  <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    estado_q <= AVALIA;
                end
                AVALIA: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= ESPERA_SOLTAR;
                    if (pontos_q != 2'd0) begin
                        if (pn_q) begin
                            if (bloqueio) begin
                                erro_q <= 1'b1;
                            end else if (timeReg_q) begin
                                scoreB_q <= diff_d;
                            end else begin
                                scoreA_q <= diff_d;
                            end
                        end else if (excede_d) begin
                            erro_q <= 1'b1;
                        end else if (timeReg_q) begin
                            scoreB_q <= soma_d[6:0];
                        end else begin
                            scoreA_q <= soma_d[6:0];
                        end
                    end
                end
                ESPERA_SOLTAR: begin
                    if (!press_q) begin
                        estado_q <= OCIOSO;
                    end
                end
                default: begin
                    estado_q <= ESPERA_SOLTAR;
                end
            endcase
        end
    end

    assign pnReg     = pn_q;
    assign pontosReg = pontos_q;
    assign scoreA    = scoreA_q;
    assign scoreB    = scoreB_q;
    assign erro      = erro_q;
    assign ocupado   = ocupado_q;

endmodule

`default_nettype wire
